// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation driver.
//   state_e : driver FSM states (IDLE, DRIVE, SETTLE, ERR)
//   JK_*    : 2-bit {J,K} codes presented to a single JK flop
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    ERR    = 2'd3
  } state_e;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excitation_driver_if.sv
// Target-request handshake into the JK excitation driver.
//   in_valid  : requester has a target
//   in_ready  : driver can accept a target
//   in_target : requested next state of the flop bank
// master = requester side, slave = driver side.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_target;

  modport master (output in_valid, output in_target, input in_ready);
  modport slave  (input in_valid, input in_target, output in_ready);
endinterface

// File: rtl/jk_excite_bit.sv
// Per-bit JK excitation: current Q and wanted next Q in, {J,K} out.
//   q      : current flop output
//   target : wanted flop output after one clock
//   jk     : {J,K}
// Macro JK_TOGGLE_EN: flipping bits use the toggle code instead of the
// single-sided set/reset code. Holding bits always get JK_HOLD.
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic       q,
  input  logic       target,
  output logic [1:0] jk
);

  always_comb begin
    jk = JK_HOLD;
    if (q != target) begin
`ifdef JK_TOGGLE_EN
      jk = JK_TOGGLE;
`else
      jk = target ? JK_SET : JK_RESET;
`endif
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Writer side of a bank of WIDTH master-slave JK flops. Accepts a target
// state, pulses J/K for one cycle from the excitation table, waits one cycle
// for the slave to update, then compares Q against the target and either
// finishes, re-drives (up to MAX_RETRY times) or raises a sticky error.
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : target handshake (slave modport)
//   q_fb         : Q outputs of the driven flops
//   j_out, k_out : J/K inputs of the driven flops
//   busy         : transfer in progress
//   done         : one-cycle pulse, Q matched the target
//   err          : sticky, retries exhausted
//   err_clr      : leaves ERR, clears err
// Macro JK_TOGGLE_EN selects toggle excitation for flipping bits.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  jk_excitation_driver_if.slave req,
  input  logic [WIDTH-1:0]   q_fb,
  output logic [WIDTH-1:0]   j_out,
  output logic [WIDTH-1:0]   k_out,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               err_clr
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_DRIVE  = DRIVE;
  localparam logic [1:0] S_SETTLE = SETTLE;
  localparam logic [1:0] S_ERR    = ERR;

  localparam int CW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [1:0]             state;
  logic [CW-1:0]          retry_cnt;
  logic [WIDTH-1:0]       target_q;
  logic [WIDTH-1:0]       exc_tgt;
  logic [WIDTH-1:0][1:0]  jk_nxt;
  logic [WIDTH-1:0]       j_nxt, k_nxt;

  // In IDLE the excitation is for the incoming target; on a retry it is
  // recomputed from the latched target against whatever Q actually reached.
  assign exc_tgt = (state == S_IDLE) ? req.in_target : target_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_excite_bit u_bit (
      .q      (q_fb[i]),
      .target (exc_tgt[i]),
      .jk     (jk_nxt[i])
    );
    assign j_nxt[i] = jk_nxt[i][1];
    assign k_nxt[i] = jk_nxt[i][0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      j_out        <= '0;
      k_out        <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      req.in_ready <= 1'b1;
      retry_cnt    <= '0;
      target_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req.in_valid) begin
            target_q  <= req.in_target;
            retry_cnt <= '0;
            if (q_fb == req.in_target) begin
              done <= 1'b1;
            end else begin
              j_out        <= j_nxt;
              k_out        <= k_nxt;
              busy         <= 1'b1;
              req.in_ready <= 1'b0;
              state        <= S_DRIVE;
            end
          end
        end
        // One-cycle J/K pulse: the flop master samples it at the next edge.
        S_DRIVE: begin
          j_out <= '0;
          k_out <= '0;
          state <= S_SETTLE;
        end
        // The slave has updated on the falling edge inside this cycle.
        S_SETTLE: begin
          if (q_fb == target_q) begin
            done         <= 1'b1;
            busy         <= 1'b0;
            req.in_ready <= 1'b1;
            state        <= S_IDLE;
          end else if (int'(retry_cnt) < MAX_RETRY) begin
            retry_cnt <= retry_cnt + CW'(1);
            j_out     <= j_nxt;
            k_out     <= k_nxt;
            state     <= S_DRIVE;
          end else begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_ERR;
          end
        end
        S_ERR: begin
          if (err_clr) begin
            err          <= 1'b0;
            req.in_ready <= 1'b1;
            state        <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
`timescale 1ns/1ps
module tb_jk_excitation_driver;
  localparam int W  = 4;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  jk_excitation_driver_if #(.WIDTH(W)) bus ();

  logic [W-1:0] q_fb, j_out, k_out;
  logic         busy, done, err, err_clr;

  jk_excitation_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus),
    .q_fb    (q_fb),
    .j_out   (j_out),
    .k_out   (k_out),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_clr (err_clr)
  );

  // Master-slave JK bank: master captures at rising edge, slave copies on the
  // falling edge. Bits in 'stuck' never leave 0. 'ld' presets the bank.
  logic [W-1:0] fm = '0, fq = '0, stuck = '0, ld_val = '0;
  logic         ld = 1'b0;
  assign q_fb = fq;
  always @(posedge clk) fm <= (j_out & ~fq) | (~k_out & fq);
  always @(negedge clk) fq <= ld ? ld_val : (fm & ~stuck);

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [W-1:0] j, k;
    logic busy, done, err, rdy;
  } exp_t;

  function automatic exp_t idle_e();
    exp_t r = '0;
    r.rdy = 1'b1;
    return r;
  endfunction

  function automatic exp_t err_e();
    exp_t r = '0;
    r.err = 1'b1;
    return r;
  endfunction

  function automatic exp_t drv_e(input logic [W-1:0] q, input logic [W-1:0] t);
    exp_t r = '0;
`ifdef JK_TOGGLE_EN
    r.j = q ^ t;
    r.k = q ^ t;
`else
    r.j = t & ~q;
    r.k = q & ~t;
`endif
    r.busy = 1'b1;
    return r;
  endfunction

  exp_t         q_exp[$];
  exp_t         e, hold_e, fin_e;
  bit           in_err = 1'b0;
  logic         m_rv, m_v, m_c;
  logic [W-1:0] m_t, m_q, cur;

  // Each accept is expanded into the per-edge expected outputs; a drive always
  // lands every non-stuck bit on the target.
  initial begin : compare
    forever begin
      @(posedge clk);
      m_rv = reset_n; m_v = bus.in_valid; m_t = bus.in_target;
      m_q = q_fb; m_c = err_clr;
      if (!m_rv) begin
        q_exp.delete(); in_err = 1'b0; e = idle_e();
      end else if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        if (e.err) in_err = 1'b1;
      end else if (in_err) begin
        if (m_c) begin in_err = 1'b0; e = idle_e(); end
        else e = err_e();
      end else begin
        e = idle_e();
        if (m_v) begin
          if (m_q == m_t) e.done = 1'b1;
          else begin
            cur = m_q;
            for (int a = 0; a <= MR; a++) begin
              q_exp.push_back(drv_e(cur, m_t));
              hold_e = '0; hold_e.busy = 1'b1;
              q_exp.push_back(hold_e);
              cur = m_t & ~stuck;
              if (cur == m_t) begin
                fin_e = idle_e(); fin_e.done = 1'b1;
                q_exp.push_back(fin_e);
                break;
              end else if (a == MR) q_exp.push_back(err_e());
            end
            e = q_exp.pop_front();
          end
        end
      end
      #1;
      chk("cycle_outputs", 32'({j_out, k_out, busy, done, err, bus.in_ready}), 32'(e));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_q(input logic [W-1:0] v);
    @(posedge clk); #2;
    ld_val = v; ld = 1'b1;
    @(negedge clk); #1;
    ld = 1'b0;
  endtask

  // Returns 1ns after the accepting edge.
  task automatic send(input logic [W-1:0] t);
    bit ok = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_target = t;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    #1 bus.in_valid = 1'b0;
    chk("accept_timeout", 32'(ok), 32'(1));
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  int pulses, gap;
  logic acc, done_at_acc;

  initial begin
    bus.in_valid = 1'b0; bus.in_target = '0; err_clr = 1'b0;
    #12;
    chk("reset_state", 32'({j_out, k_out, busy, done, err, bus.in_ready}), 32'(12'b0000_0000_0001));
    @(negedge clk); reset_n = 1'b1;

    // basic transfer 0000 -> 1010
    set_q(4'b0000);
    send(4'b1010);
    chk("basic_j", 32'(j_out), 32'(4'b1010));
    chk("basic_k", 32'(k_out), 32'(4'b0000));
    edge1();
    chk("basic_j_pulse_end", 32'(j_out), 32'(0));
    edge1();
    chk("basic_done", 32'(done), 32'(1));
    chk("basic_q", 32'(q_fb), 32'(4'b1010));
    chk("basic_err", 32'(err), 32'(0));

    // mixed 1010 -> 0110
    send(4'b0110);
`ifdef JK_TOGGLE_EN
    chk("mixed_j", 32'(j_out), 32'(4'b1100));
    chk("mixed_k", 32'(k_out), 32'(4'b1100));
`else
    chk("mixed_j", 32'(j_out), 32'(4'b0100));
    chk("mixed_k", 32'(k_out), 32'(4'b1000));
`endif
    edge1(); edge1();
    chk("mixed_done", 32'(done), 32'(1));
    chk("mixed_q", 32'(q_fb), 32'(4'b0110));

    // no-op 0110 -> 0110
    send(4'b0110);
    chk("noop_done", 32'(done), 32'(1));
    chk("noop_jk", 32'({j_out, k_out}), 32'(0));
    chk("noop_ready", 32'(bus.in_ready), 32'(1));
    edge1();
    chk("noop_done_pulse", 32'(done), 32'(0));

    // handshake: valid held through busy with a new target
    send(4'b0011);
    bus.in_valid = 1'b1; bus.in_target = 4'b1100;
    gap = 0; acc = 1'b0; done_at_acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); gap++;
      if (bus.in_ready) begin acc = 1'b1; done_at_acc = done; break; end
    end
    #1 bus.in_valid = 1'b0;
    chk("hs_accept", 32'(acc), 32'(1));
    chk("hs_gap", 32'(gap), 32'(3));
    chk("hs_done_at_accept", 32'(done_at_acc), 32'(1));
    edge1(); edge1();
    chk("hs_q", 32'(q_fb), 32'(4'b1100));

    // reset during DRIVE
    send(4'b0000);
    chk("rst_pre_k", 32'(k_out), 32'(4'b1100));
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_jk", 32'({j_out, k_out}), 32'(0));
    @(posedge clk); @(negedge clk); reset_n = 1'b1;
    #1;
    chk("rst_release", 32'({busy, done, err, bus.in_ready}), 32'(4'b0001));
    chk("rst_q_held", 32'(q_fb), 32'(4'b1100));

    // err_clr outside ERR does nothing
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;

    // retry and error with bit0 stuck at 0
    stuck = 4'b0001;
    set_q(4'b0000);
    send(4'b0001);
    pulses = (j_out != 0 || k_out != 0) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      edge1();
      if (j_out != 0 || k_out != 0) pulses++;
      if (err) break;
    end
    chk("retry_pulses", 32'(pulses), 32'(3));
    chk("retry_err", 32'(err), 32'(1));
    chk("retry_ready", 32'(bus.in_ready), 32'(0));
    edge1(); edge1();
    chk("err_sticky", 32'(err), 32'(1));
    @(negedge clk); err_clr = 1'b1;
    edge1();
    err_clr = 1'b0;
    chk("errclr_err", 32'(err), 32'(0));
    chk("errclr_ready", 32'(bus.in_ready), 32'(1));
    stuck = 4'b0000;

    // normal transfer after recovery
    send(4'b1001);
    edge1(); edge1();
    chk("post_done", 32'(done), 32'(1));
    chk("post_q", 32'(q_fb), 32'(4'b1001));

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Drives the J/K inputs of a bank of WIDTH master-slave JK flip-flops. This is the writer side of the JK flop interface.
- Accepts a target state over a valid/ready handshake and derives per-bit J/K from the excitation table, using the flops' Q feedback.
- Pulses J/K for one cycle, checks that Q reached the target, and retries or flags an error.
- Sits between control logic and any JK-flop register bank in the sequential-circuits library.

Parameters:
- WIDTH, 4, number of JK flops driven.
- MAX_RETRY, 2, number of re-drive attempts after a mismatch before error (0 = no retry).

Ports:
- clk  input  1  system clock; the driven flops use the same clk.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  target request valid.
- in_ready  output  1  driver can accept a target.
- in_target  input  WIDTH  requested next state of the flop bank.
- q_fb  input  WIDTH  Q outputs of the driven flops.
- j_out  output  WIDTH  J inputs to the flops.
- k_out  output  WIDTH  K inputs to the flops.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse: q_fb equals the target.
- err  output  1  sticky: retries exhausted.
- err_clr  input  1  clears err; returns from ERR to IDLE.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE, j_out=0, k_out=0, done=0, err=0, busy=0, in_ready=1, retry count=0, target register=0.
- Reset asserted mid-operation aborts immediately. J/K are forced to 0, so the flops see hold.
- All outputs are registered; in_ready is 1 only in IDLE.
- Excitation per bit, from current q_fb to target:
  - 0->0: J=0, K=0
  - 0->1: J=1, K=0
  - 1->0: J=0, K=1
  - 1->1: J=0, K=0
- States:
  - IDLE: on in_valid&&in_ready at edge T, latch in_target and clear the retry count.
    - If q_fb==in_target: done=1 for cycle T..T+1, stay IDLE.
    - Else: load j_out/k_out from the excitation, go to DRIVE, busy=1.
  - DRIVE: J/K are held stable for exactly one cycle (T..T+1). The flop master samples them at edge T+1. At T+1, j_out=k_out=0 and go to SETTLE.
  - SETTLE: the flop slave updates Q at the falling edge inside cycle T+1..T+2. At edge T+2, compare q_fb to the latched target.
    - Match: done=1 for one cycle, busy=0, go to IDLE.
    - Mismatch with retry count < MAX_RETRY: increment the count, recompute J/K from the current q_fb, go to DRIVE.
    - Mismatch with retry count == MAX_RETRY: err=1, go to ERR.
  - ERR: busy=0, in_ready=0, J/K=0. err_clr at an edge clears err and goes to IDLE.
- Latencies:
  - Nominal accept-to-done is 3 edges, so done is visible after edge T+2.
  - Each retry adds 2 cycles.
- in_valid while busy is ignored; the requester must hold in_valid until in_ready.
- err_clr outside ERR has no effect.
- q_fb changing outside SETTLE is not checked.

Optional Feature:
- Macro: JK_TOGGLE_EN.
- With the macro defined: bits that must flip use J=1, K=1 (toggle) instead of the single-sided code. Bits that hold use J=0, K=0.
- Without the macro: the single-sided table above applies.
- Timing and states are identical in both builds.

Decomposition:
- Shared package jk_pkg:
  - state enum (IDLE, DRIVE, SETTLE, ERR)
  - 2-bit JK code constants: JK_HOLD=00, JK_RESET=01, JK_SET=10, JK_TOGGLE=11.
- Sub-module jk_excite_bit: combinational, q/target in, {J,K} out, JK_TOGGLE_EN-aware. It is instantiated WIDTH times in a generate loop.

Test Plan:
- Basic transfer. Connect WIDTH=4 master_slave JK flops; reset; send target 4'b1010 from Q=0000 -> J=1010, K=0000 for one cycle; done pulse 3 edges after accept; q_fb=1010; err=0.
- Mixed transition. From Q=1010, target 0110 -> J=0100, K=1000 in the default build; with JK_TOGGLE_EN, J=K=1100; final Q=0110 in both builds.
- No-op. Target equal to q_fb (0110) -> J/K stay 0; done the cycle after accept; state remains IDLE.
- Retry and error. Flops replaced by a model that sticks bit0 at 0; target 0001 with MAX_RETRY=2 -> three DRIVE pulses, then err=1 and in_ready=0; err_clr -> IDLE, in_ready=1.
- Reset mid-operation. Assert reset_n=0 during DRIVE -> j_out/k_out go to 0 asynchronously; done=0, err=0, in_ready=1 after release.
- Handshake. in_valid held with a new target while busy -> not accepted until done; then accepted on the next edge with in_ready=1.
